// File: rtl/dda_pkg.sv
// Shared constants, frame codes and FSM state type for the Lorenz DDA tile
// command parser.
package dda_pkg;

  localparam int REG_SIZE = 14;
  localparam int PARAM_W  = 8 * REG_SIZE;
  localparam int IDX_W    = $clog2(REG_SIZE);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_HALT  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;

  // icx=-1.0, icy=0.1, icz=25.0, sigma=10, beta=8/3, rho=28, dt=1/256
  localparam logic [PARAM_W-1:0] PARAM_DEFAULTS =
    112'hC000_14CD_7240_6A00_5555_7300_0400;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } state_t;

  // Running modulo-256 checksum accumulation.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/param_loader_rx_timeout.sv
// Inter-byte timeout counter: clears on request, counts while enabled and
// saturates at TIMEOUT_CYCLES, where it reports expiry.
module rx_timeout #(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = (cnt_q == CNT_MAX);

  // Next count: clear has priority, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_loader.sv
// Receive-side command parser: decodes SYNC/CMD/payload/CHK frames from the
// UART, holds the DDA parameter register file, commits it atomically on a
// valid checksum and drives the DDA run enable.
module param_loader
  import dda_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_error,
  output logic [8*REG_SIZE-1:0]   params,
  output logic                    load,
  output logic                    dda_en,
  output logic                    busy,
  output logic                    frame_err
);

  state_t                       state_q, state_d;
  logic [7:0]                   cmd_q, cmd_d;
  logic [7:0]                   sum_q, sum_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [0:REG_SIZE-1][7:0]     shadow_q, shadow_d;
  logic [PARAM_W-1:0]           params_q, params_d;
  logic                         dda_en_q, dda_en_d;
  logic                         load_q, load_d;
  logic                         busy_q, busy_d;
  logic                         frame_err_q, frame_err_d;

  logic                         tmo_clear_s;
  logic                         tmo_expired_s;
  logic [7:0]                   chk_sum_s;

  // The timeout only runs while a frame is open and restarts on every byte.
  assign tmo_clear_s = rx_valid || (state_q == ST_IDLE);

  rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear_s),
    .enable  (1'b1),
    .expired (tmo_expired_s)
  );

  assign chk_sum_s = sum8(sum_q, rx_byte);

  // Frame decoder: rx_error beats a byte, a byte beats the timeout.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    params_d    = params_q;
    dda_en_d    = dda_en_q;
    load_d      = 1'b0;
    frame_err_d = 1'b0;

    if (rx_error) begin
      if (state_q != ST_IDLE) begin
        frame_err_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == SYNC_BYTE) begin
            state_d = ST_CMD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          cmd_d = rx_byte;
          sum_d = rx_byte;
          idx_d = {IDX_W{1'b0}};
          case (rx_byte)
            CMD_LOAD: state_d = ST_PAYLOAD;
            CMD_HALT: state_d = ST_CHK;
            CMD_RUN:  state_d = ST_CHK;
            default: begin
              frame_err_d = 1'b1;
              state_d     = ST_IDLE;
            end
          endcase
        end
        ST_PAYLOAD: begin
          // 0xA5 here is ordinary data; there is no resync.
          shadow_d[idx_q] = rx_byte;
          sum_d           = chk_sum_s;
          if (idx_q == IDX_W'(REG_SIZE - 1)) begin
            state_d = ST_CHK;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (chk_sum_s == 8'h00) begin
            case (cmd_q)
              CMD_LOAD: begin
                params_d = shadow_q;
                load_d   = 1'b1;
              end
              CMD_HALT: dda_en_d = 1'b0;
              CMD_RUN:  dda_en_d = 1'b1;
              default:  dda_en_d = dda_en_q;
            endcase
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && tmo_expired_s) begin
      frame_err_d = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, shadow buffer, committed parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 8'h00;
      sum_q       <= 8'h00;
      idx_q       <= {IDX_W{1'b0}};
      shadow_q    <= '0;
      params_q    <= PARAM_DEFAULTS;
      dda_en_q    <= 1'b1;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      params_q    <= params_d;
      dda_en_q    <= dda_en_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign params    = params_q;
  assign load      = load_q;
  assign dda_en    = dda_en_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_param_loader.sv
// Scoreboard bench for param_loader: every frame's expected outcome is queued
// when issued; a monitor pops and compares when busy falls.
module tb_param_loader;

  localparam int TMO = 25000;
  localparam logic [111:0] DEFAULTS = 112'hC000_14CD_7240_6A00_5555_7300_0400;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_error = 1'b0;
  logic [111:0] params;
  logic         load, dda_en, busy, frame_err;

  param_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_error(rx_error), .params(params), .load(load), .dda_en(dda_en),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ld;
    logic         err;
    logic [111:0] prm;
    logic         en;
  } exp_t;

  exp_t         exp_q[$];
  int           compared = 0;
  int           mismatched = 0;
  logic [111:0] model_params = DEFAULTS;
  logic         model_en = 1'b1;
  logic         prev_busy = 1'b0;

  task automatic push_exp(input logic ld, input logic err);
    exp_t e;
    e.ld = ld; e.err = err; e.prm = model_params; e.en = model_en;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic ok, input string name, input logic [127:0] act, input logic [127:0] req);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Pops the expected outcome each time a frame closes; pulses at any other time are errors.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_frame_end", 128'(busy), 128'(1));
        end else begin
          e = exp_q.pop_front();
          compared++;
          if (load !== e.ld || frame_err !== e.err || dda_en !== e.en || params !== e.prm) begin
            mismatched++;
            $display("FAIL frame_result: got load=%0b err=%0b en=%0b params=%h, want load=%0b err=%0b en=%0b params=%h",
                     load, frame_err, dda_en, params, e.ld, e.err, e.en, e.prm);
          end
        end
      end else if (load || frame_err) begin
        check(1'b0, "spurious_pulse", {126'd0, load, frame_err}, 128'd0);
      end
      prev_busy = busy;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1; rx_byte = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Builds a frame, predicts its outcome from the protocol rules, then sends it.
  // err_pos > 0 replaces the byte at that position with an rx_error strobe.
  task automatic do_frame(input logic [7:0] cmd, input logic [7:0] chk_xor,
                          input int err_pos, input int maxgap, input logic zero_pl);
    logic [7:0]   fr[$];
    logic [7:0]   sum;
    logic [111:0] newp;
    int           plen;
    bit           known;
    fr.push_back(8'hA5);
    fr.push_back(cmd);
    known = (cmd == 8'h01) || (cmd == 8'h02) || (cmd == 8'h03);
    plen  = (cmd == 8'h01) ? 14 : 0;
    sum   = cmd;
    newp  = model_params;
    if (known) begin
      for (int i = 0; i < plen; i++) begin
        logic [7:0] b;
        b = zero_pl ? 8'h00 : 8'($urandom);
        fr.push_back(b);
        sum  = sum + b;
        newp = {newp[103:0], b};
      end
      fr.push_back((8'h00 - sum) ^ chk_xor);
    end
    if (err_pos > 0 && err_pos < fr.size()) begin
      push_exp(1'b0, 1'b1);
    end else if (!known || chk_xor != 8'h00) begin
      push_exp(1'b0, 1'b1);
    end else if (cmd == 8'h01) begin
      model_params = newp;
      push_exp(1'b1, 1'b0);
    end else begin
      model_en = (cmd == 8'h03);
      push_exp(1'b0, 1'b0);
    end
    for (int i = 0; i < fr.size(); i++) begin
      if (err_pos > 0 && i == err_pos) begin
        rx_error = 1'b1; rx_valid = 1'($urandom); rx_byte = fr[i];
        @(negedge clk);
        rx_error = 1'b0; rx_valid = 1'b0;
        break;
      end
      send_byte(fr[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  initial begin
    int waited;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check(params == DEFAULTS, "reset_params", 128'(params), 128'(DEFAULTS));
    check(dda_en == 1'b1, "reset_dda_en", 128'(dda_en), 128'(1));
    check(busy == 1'b0, "reset_busy", 128'(busy), 128'(0));
    check(load == 1'b0, "reset_load", 128'(load), 128'(0));
    check(frame_err == 1'b0, "reset_frame_err", 128'(frame_err), 128'(0));
    prev_busy = busy;
    fork monitor_loop(); join_none

    // HALT then RUN
    do_frame(8'h02, 8'h00, 0, 1, 1'b0);
    do_frame(8'h03, 8'h00, 0, 0, 1'b0);
    // LOAD of zeros with a bad checksum, then a good one
    do_frame(8'h01, 8'h01, 0, 1, 1'b1);
    do_frame(8'h01, 8'h00, 0, 1, 1'b1);
    // Junk byte and stray rx_error in IDLE are ignored
    send_byte(8'h42, 2);
    rx_error = 1'b1; @(negedge clk); rx_error = 1'b0; @(negedge clk);
    // Unknown command
    do_frame(8'h7F, 8'h00, 0, 1, 1'b0);
    // rx_error in the middle of a payload
    do_frame(8'h01, 8'h00, 7, 1, 1'b0);

    // Reset in the middle of a LOAD restores defaults without a load pulse
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    model_params = DEFAULTS; model_en = 1'b1;
    push_exp(1'b0, 1'b0);
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);

    // Inter-byte timeout after 5 payload bytes
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 3), 0);
    push_exp(1'b0, 1'b1);
    waited = 0;
    while (busy && waited < TMO + 20) begin
      @(negedge clk);
      waited++;
    end
    check(!busy && waited >= TMO && waited <= TMO + 2, "timeout_latency",
          128'(waited), 128'(TMO + 1));
    do_frame(8'h03, 8'h00, 0, 0, 1'b0);

    // Randomized frames, some back-to-back, with junk, bad checksums and aborts
    for (int n = 0; n < 150; n++) begin
      logic [7:0] cmd;
      logic [7:0] cx;
      int         ep;
      int         r;
      r   = int'($urandom_range(0, 9));
      cmd = (r < 5) ? 8'h01 : (r < 7) ? 8'h02 : (r < 9) ? 8'h03 : 8'($urandom_range(4, 255));
      cx  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      ep  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 16)) : 0;
      if ($urandom_range(0, 4) == 0) begin
        logic [7:0] j;
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h42;
        send_byte(j, int'($urandom_range(0, 2)));
      end
      do_frame(cmd, cx, ep, int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (10) @(negedge clk);
    check(exp_q.size() == 0, "scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
